chain_score_sched: RTL

- Sequencer for the pipelined anchor-pair score unit in the chaining DP stage.
- For one current anchor i, walks predecessors j = i-1 down to i-n_eff and reads each predecessor's coordinates and stored f-score from anchor memory.
- Issues each pair to the score unit and tracks in-flight results with a latency-matched delay line.
- Reduces the returned candidates (f[j] + score) to the best f[i] and its predecessor index, then pulses done.

---
 rtl/chain_score_sched_if.sv | 28 ++
 rtl/chain_score_sched.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/chain_score_sched_if.sv
// Anchor-memory read port and score-unit issue/return port of the chaining sequencer.
// master = sequencer side, slave = memory / score-unit side.
interface chain_score_sched_if #(
    parameter int IDX_W = 16
) ();
    logic             rd_en;
    logic [IDX_W-1:0] rd_addr;
    logic [31:0]      rd_rx;
    logic [31:0]      rd_qx;
    logic [31:0]      rd_f;
    logic             sc_valid;
    logic [31:0]      sc_riX;
    logic [31:0]      sc_riY;
    logic [31:0]      sc_qiX;
    logic [31:0]      sc_qiY;
    logic [31:0]      sc_W;
    logic [31:0]      sc_result;

    modport master (
        output rd_en, rd_addr, sc_valid, sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W,
        input  rd_rx, rd_qx, rd_f, sc_result
    );

    modport slave (
        input  rd_en, rd_addr, sc_valid, sc_riX, sc_riY, sc_qiX, sc_qiY, sc_W,
        output rd_rx, rd_qx, rd_f, sc_result
    );
endinterface

// File: rtl/chain_score_sched.sv
// Predecessor walker / best-score reducer for the chaining DP score unit.
// Optional CHAIN_SKIP_CNT_EN adds a saturating count of gated candidates on skip_cnt.
module chain_score_sched #(
    parameter int IDX_W     = 16,
    parameter int N_PRED    = 64,
    parameter int SCORE_LAT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic [31:0]          i_x,
    input  logic [31:0]          i_y,
    input  logic [7:0]           n_pred,
    input  logic [31:0]          w,
    output logic                 busy,
    chain_score_sched_if.master  bus,
    output logic                 done,
    output logic [31:0]          best_f,
    output logic [IDX_W-1:0]     best_p,
    output logic [15:0]          skip_cnt
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [SCORE_LAT-1:0] VLD_TOP = SCORE_LAT'(1) << (SCORE_LAT - 1);

    logic [1:0]           state;
    logic [IDX_W-1:0]     remain;
    logic [IDX_W-1:0]     addr_r;
    logic [IDX_W-1:0]     j_q;
    logic                 rd_en_q;
    logic [31:0]          ix_q;
    logic [31:0]          iy_q;
    logic [31:0]          w_q;
    logic [IDX_W-1:0]     n_eff_c;
    logic                 gate_c;
    logic                 pending;
    logic [31:0]          cand;

    logic [SCORE_LAT-1:0] vld;
    logic [SCORE_LAT-1:0] gate_d;
    logic [IDX_W-1:0]     j_d [SCORE_LAT];
    logic [31:0]          f_d [SCORE_LAT];

    always_comb begin
        n_eff_c = IDX_W'(n_pred);
        if (n_eff_c > IDX_W'(N_PRED)) n_eff_c = IDX_W'(N_PRED);
        if (n_eff_c > i_idx)          n_eff_c = i_idx;
    end

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign bus.rd_en    = (state == S_ISSUE);
    assign bus.rd_addr  = addr_r;
    assign bus.sc_valid = rd_en_q;

    // Memory data is only forwarded while it is a live read; otherwise the bus rests at zero.
    assign bus.sc_riX = rd_en_q ? ix_q      : '0;
    assign bus.sc_riY = rd_en_q ? bus.rd_rx : '0;
    assign bus.sc_qiX = rd_en_q ? iy_q      : '0;
    assign bus.sc_qiY = rd_en_q ? bus.rd_qx : '0;
    assign bus.sc_W   = rd_en_q ? w_q       : '0;

    assign gate_c  = (bus.rd_rx >= ix_q) || (bus.rd_qx >= iy_q);
    assign cand    = f_d[SCORE_LAT-1] + bus.sc_result;
    // The result arriving this cycle registers on the same edge we leave DRAIN.
    assign pending = bus.sc_valid || (|(vld & ~VLD_TOP));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            remain  <= '0;
            addr_r  <= '0;
            j_q     <= '0;
            rd_en_q <= 1'b0;
            ix_q    <= '0;
            iy_q    <= '0;
            w_q     <= '0;
            best_f  <= '0;
            best_p  <= '1;
            vld     <= '0;
            gate_d  <= '0;
            for (int k = 0; k < SCORE_LAT; k++) begin
                j_d[k] <= '0;
                f_d[k] <= '0;
            end
        end else begin
            rd_en_q <= bus.rd_en;
            if (bus.rd_en) j_q <= addr_r;

            vld[0]    <= bus.sc_valid;
            gate_d[0] <= gate_c;
            j_d[0]    <= j_q;
            f_d[0]    <= bus.rd_f;
            for (int k = 1; k < SCORE_LAT; k++) begin
                vld[k]    <= vld[k-1];
                gate_d[k] <= gate_d[k-1];
                j_d[k]    <= j_d[k-1];
                f_d[k]    <= f_d[k-1];
            end

            if (vld[SCORE_LAT-1] && !gate_d[SCORE_LAT-1] && ($signed(cand) > $signed(best_f))) begin
                best_f <= cand;
                best_p <= j_d[SCORE_LAT-1];
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        ix_q   <= i_x;
                        iy_q   <= i_y;
                        w_q    <= w;
                        best_f <= w;
                        best_p <= '1;
                        remain <= n_eff_c;
                        addr_r <= i_idx - 1'b1;
                        state  <= (n_eff_c != '0) ? S_ISSUE : S_DRAIN;
                    end
                end
                S_ISSUE: begin
                    if (remain == IDX_W'(1)) begin
                        state <= S_DRAIN;
                    end else begin
                        remain <= remain - 1'b1;
                        addr_r <= addr_r - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!pending) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CHAIN_SKIP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            skip_cnt <= '0;
        end else if (vld[SCORE_LAT-1] && gate_d[SCORE_LAT-1] && (skip_cnt != 16'hFFFF)) begin
            skip_cnt <= skip_cnt + 16'd1;
        end
    end
`else
    assign skip_cnt = '0;
`endif

endmodule
